// File: rtl/uart_img_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_img_pkg
// Description : Shared definitions for the UART image path. Holds the packer
//               FSM state encoding and the fixed header word order.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_img_pkg;

   // Packer control states: header capture, pixel streaming, header fault
   typedef enum logic [1:0] {
      S_HDR = 2'd0,
      S_PIX = 2'd1,
      S_ERR = 2'd2
   } state_e;

   // Position of each field within the image header
   localparam int unsigned HDR_W_IDX = 0;
   localparam int unsigned HDR_H_IDX = 1;
   localparam int unsigned HDR_X_IDX = 2;
   localparam int unsigned HDR_Y_IDX = 3;

endpackage
`default_nettype wire

// File: rtl/uart_bit_packer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_packer
// Description : Little-endian byte-to-word accumulator. Each byte lands above
//               the bits already held; once PIX_W bits are available the low
//               PIX_W bits are emitted as a word (combinationally, on the byte
//               cycle) and the remainder shifts down.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_packer #(
   parameter int unsigned PIX_W = 12
) (
   input  logic             clk_uart,
   input  logic             rst_n,
   input  logic             byte_valid_i,
   input  logic [7:0]       byte_data_i,
   input  logic             clear_i,
   output logic             word_valid_o,
   output logic [PIX_W-1:0] word_o,
   output logic             acc_nonempty_o
);

   // Bit counter never exceeds PIX_W-1+8 = 23 for the legal widths
   localparam int unsigned CNT_W = 5;

   // Held bits are always fewer than PIX_W, and bits above cnt_q are zero
   logic [PIX_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PIX_W+7:0] w_merged;
   logic [CNT_W-1:0] w_cnt_sum;

   assign w_merged       = {8'd0, acc_q} | ({{PIX_W{1'b0}}, byte_data_i} << cnt_q);
   assign w_cnt_sum      = cnt_q + CNT_W'(8);
   assign word_o         = w_merged[PIX_W-1:0];
   assign acc_nonempty_o = (cnt_q != '0);

   // Merge the incoming byte and split off a full word when enough bits exist
   always_comb begin
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      word_valid_o = 1'b0;
      if (clear_i) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (byte_valid_i) begin
         if (w_cnt_sum >= CNT_W'(PIX_W)) begin
            word_valid_o = 1'b1;
            acc_d        = PIX_W'(w_merged[PIX_W+7:PIX_W]);
            cnt_d        = w_cnt_sum - CNT_W'(PIX_W);
         end else begin
            acc_d = w_merged[PIX_W-1:0];
            cnt_d = w_cnt_sum;
         end
      end
   end

   // Accumulator state register
   always_ff @(posedge clk_uart or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : uart_pixel_packer
// Description : Packs the UART byte stream into PIX_W-bit words, captures the
//               4-word image header and streams pixels into SRAM through a
//               single-slot req/ack write port. Pixels refresh continuously
//               from address HDR_WORDS once a frame completes.
//               Optional macro UART_PIXEL_PACKER_RESYNC_EN adds an idle
//               timeout that returns the packer to header capture.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_pixel_packer
   import uart_img_pkg::*;
#(
   parameter int unsigned PIX_W       = 12,
   parameter int unsigned ADDR_W      = 19,
   parameter int unsigned DIM_W       = 11,
   parameter int unsigned HDR_WORDS   = 4,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic              clk_uart,
   input  logic              rst_n,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              wr_req,
   input  logic              wr_ack,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PIX_W-1:0]  wr_data,
   output logic [DIM_W-1:0]  img_width,
   output logic [DIM_W-1:0]  img_height,
   output logic [DIM_W-1:0]  img_x,
   output logic [DIM_W-1:0]  img_y,
   output logic              hdr_valid,
   output logic              frame_done,
   output logic              overflow,
   output logic              hdr_err
);

   localparam int unsigned HIDX_W = $clog2(HDR_WORDS) + 1;
   localparam int unsigned TOT_W  = 2 * DIM_W;

   if (!(PIX_W == 8 || PIX_W == 12 || PIX_W == 16) || TIMEOUT_CYC < 2) begin : g_bad_params
      $error("uart_pixel_packer: PIX_W must be 8, 12 or 16 and TIMEOUT_CYC at least 2");
   end

   state_e              state_q, state_d;
   logic [HIDX_W-1:0]   hdr_idx_q, hdr_idx_d;
   logic [TOT_W-1:0]    pix_idx_q, pix_idx_d;
   logic [TOT_W-1:0]    pix_total_q, pix_total_d;
   logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
   logic                wr_req_q, wr_req_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [PIX_W-1:0]    wr_data_q, wr_data_d;
   logic [DIM_W-1:0]    img_width_q, img_width_d;
   logic [DIM_W-1:0]    img_height_q, img_height_d;
   logic [DIM_W-1:0]    img_x_q, img_x_d;
   logic [DIM_W-1:0]    img_y_q, img_y_d;
   logic                hdr_valid_q, hdr_valid_d;
   logic                frame_done_q, frame_done_d;
   logic                overflow_q, overflow_d;
   logic                hdr_err_q, hdr_err_d;
   logic                last_hdr_q, last_hdr_d;
   logic                last_pix_q, last_pix_d;

   logic                w_pk_valid;
   logic                w_word_valid;
   logic [PIX_W-1:0]    w_word;
   logic [DIM_W-1:0]    w_word_dim;
   logic                w_acc_nonempty;
   logic                w_resync;
   logic                w_ack;
   logic                w_hdr_done;
   logic                w_dims_ok;
   logic                w_slot_free;
   logic                w_take;
   logic [TOT_W-1:0]    w_total;
   logic [TOT_W-1:0]    w_total_eff;
   state_e              w_state_eff;

   // Bytes arriving after a header fault never reach the accumulator
   assign w_pk_valid = byte_valid && (state_q != S_ERR);

   uart_bit_packer #(
      .PIX_W (PIX_W)
   ) u_bit_packer (
      .clk_uart       (clk_uart),
      .rst_n          (rst_n),
      .byte_valid_i   (w_pk_valid),
      .byte_data_i    (byte_data),
      .clear_i        (w_resync),
      .word_valid_o   (w_word_valid),
      .word_o         (w_word),
      .acc_nonempty_o (w_acc_nonempty)
   );

   // Header fields are the word truncated or zero-extended to DIM_W
   for (genvar b = 0; b < DIM_W; b++) begin : g_dim_bits
      if (b < PIX_W) begin : g_copy
         assign w_word_dim[b] = w_word[b];
      end else begin : g_zero
         assign w_word_dim[b] = 1'b0;
      end
   end

`ifdef UART_PIXEL_PACKER_RESYNC_EN
   localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC);

   logic [IDLE_W-1:0] idle_q, idle_d;

   // Count idle cycles; the last idle cycle of the window triggers a resync
   always_comb begin
      idle_d   = idle_q;
      w_resync = 1'b0;
      if (byte_valid) begin
         idle_d = '0;
      end else if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
         w_resync = w_acc_nonempty || (state_q != S_HDR);
      end else begin
         idle_d = idle_q + IDLE_W'(1);
      end
   end

   // Idle counter register
   always_ff @(posedge clk_uart or negedge rst_n) begin
      if (!rst_n) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   logic w_unused_nonempty;

   assign w_resync          = 1'b0;
   assign w_unused_nonempty = w_acc_nonempty;
`endif

   // The last header write completing decides the state a same-cycle word sees
   assign w_ack       = wr_req_q & wr_ack;
   assign w_hdr_done  = w_ack & last_hdr_q;
   assign w_dims_ok   = (img_width_q != '0) && (img_height_q != '0);
   assign w_total     = TOT_W'(img_width_q) * TOT_W'(img_height_q);
   assign w_total_eff = w_hdr_done ? w_total : pix_total_q;
   assign w_state_eff = w_hdr_done ? (w_dims_ok ? S_PIX : S_ERR) : state_q;
   assign w_slot_free = ~wr_req_q | wr_ack;
   assign w_take      = w_word_valid && (w_state_eff != S_ERR);

   // Next-state logic: handshake slot, header capture, pixel addressing
   always_comb begin
      state_d      = state_q;
      hdr_idx_d    = hdr_idx_q;
      pix_idx_d    = pix_idx_q;
      pix_total_d  = pix_total_q;
      next_addr_d  = next_addr_q;
      wr_req_d     = wr_req_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      img_width_d  = img_width_q;
      img_height_d = img_height_q;
      img_x_d      = img_x_q;
      img_y_d      = img_y_q;
      hdr_valid_d  = hdr_valid_q;
      frame_done_d = 1'b0;
      overflow_d   = overflow_q;
      hdr_err_d    = hdr_err_q;
      last_hdr_d   = last_hdr_q;
      last_pix_d   = last_pix_q;

      if (w_ack) begin
         wr_req_d     = 1'b0;
         last_hdr_d   = 1'b0;
         last_pix_d   = 1'b0;
         frame_done_d = last_pix_q;
      end

      if (w_hdr_done) begin
         state_d     = w_state_eff;
         pix_total_d = w_total;
         hdr_valid_d = w_dims_ok;
         hdr_err_d   = hdr_err_q | ~w_dims_ok;
      end

      if (w_take) begin
         if (w_slot_free) begin
            wr_req_d    = 1'b1;
            wr_data_d   = w_word;
            wr_addr_d   = next_addr_q;
            next_addr_d = next_addr_q + ADDR_W'(1);
            if (w_state_eff == S_HDR) begin
               case (hdr_idx_q)
                  HIDX_W'(HDR_W_IDX): img_width_d  = w_word_dim;
                  HIDX_W'(HDR_H_IDX): img_height_d = w_word_dim;
                  HIDX_W'(HDR_X_IDX): img_x_d      = w_word_dim;
                  HIDX_W'(HDR_Y_IDX): img_y_d      = w_word_dim;
                  default: ;
               endcase
               hdr_idx_d  = hdr_idx_q + HIDX_W'(1);
               last_hdr_d = (hdr_idx_q == HIDX_W'(HDR_WORDS - 1));
            end else begin
               if (pix_idx_q == w_total_eff - TOT_W'(1)) begin
                  pix_idx_d   = '0;
                  next_addr_d = ADDR_W'(HDR_WORDS);
                  last_pix_d  = 1'b1;
               end else begin
                  pix_idx_d = pix_idx_q + TOT_W'(1);
               end
            end
         end else begin
            overflow_d = 1'b1;
         end
      end

      // Resync only fires on idle cycles, so no word is taken alongside it
      if (w_resync) begin
         state_d     = S_HDR;
         hdr_idx_d   = '0;
         pix_idx_d   = '0;
         next_addr_d = '0;
         hdr_valid_d = 1'b0;
         last_hdr_d  = 1'b0;
         last_pix_d  = 1'b0;
      end
   end

   // Control and output registers
   always_ff @(posedge clk_uart or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_HDR;
         hdr_idx_q    <= '0;
         pix_idx_q    <= '0;
         pix_total_q  <= '0;
         next_addr_q  <= '0;
         wr_req_q     <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         img_width_q  <= '0;
         img_height_q <= '0;
         img_x_q      <= '0;
         img_y_q      <= '0;
         hdr_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         hdr_err_q    <= 1'b0;
         last_hdr_q   <= 1'b0;
         last_pix_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         hdr_idx_q    <= hdr_idx_d;
         pix_idx_q    <= pix_idx_d;
         pix_total_q  <= pix_total_d;
         next_addr_q  <= next_addr_d;
         wr_req_q     <= wr_req_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         img_width_q  <= img_width_d;
         img_height_q <= img_height_d;
         img_x_q      <= img_x_d;
         img_y_q      <= img_y_d;
         hdr_valid_q  <= hdr_valid_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         hdr_err_q    <= hdr_err_d;
         last_hdr_q   <= last_hdr_d;
         last_pix_q   <= last_pix_d;
      end
   end

   assign wr_req     = wr_req_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign img_width  = img_width_q;
   assign img_height = img_height_q;
   assign img_x      = img_x_q;
   assign img_y      = img_y_q;
   assign hdr_valid  = hdr_valid_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign hdr_err    = hdr_err_q;

endmodule
`default_nettype wire
